fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//   Upstream companion to the tapped-delay FIR: accepts coefficients b0..bDELAYS over a
//   valid/ready write stream into a shadow bank. Copies the full set to the packed
//   coefficient bus b on the next sample boundary, so the filter never sees a half-written set.
//   Sits between the host/config path and the filter's b input.
// PARAMETERS
//   DELAYS  3   number of delay stages; filter has DELAYS+1 taps (DELAYS >= 1)
//   N       32  coefficient width in bits (matches filter data width)
// PORTS
//   clk          in   1               system clock, all logic on rising edge
//   rst          in   1               asynchronous, active-high reset
//   wr_valid     in   1               host presents a coefficient word
//   wr_ready     out  1               loader accepts word this cycle (transfer = valid&ready)
//   wr_data      in   N               coefficient value, two's complement
//   wr_last      in   1               marks final word of a set (must be tap DELAYS)
//   clear        in   1               synchronous abort: discard shadow, clear err
//   sample_strobe in  1               one-cycle pulse at each filter sample boundary
//   b            out  (DELAYS+1)*N    active coefficients; tap k at b[(k+1)*N-1 : k*N]
//   busy         out  1               high in LOAD or PEND
//   commit_done  out  1               one-cycle pulse when b is updated
//   err          out  1               sticky framing error flag
// BEHAVIOUR
//   Reset (async): state=IDLE, idx=0, b=0, shadow=0, wr_ready=0 until first clk after
//     rst deasserts, commit_done=0, err=0, busy=0.
//   States:
//   - IDLE: wr_ready=1. On transfer: shadow[0]<=wr_data, idx<=1, go LOAD.
//     wr_last=1 on this word -> framing error.
//   - LOAD: wr_ready=1. On transfer: shadow[idx]<=wr_data.
//     idx<DELAYS & wr_last=0 -> idx++.
//     idx==DELAYS & wr_last=1 -> go PEND.
//     Any other wr_last combination -> framing error.
//   - PEND: wr_ready=0. On sample_strobe: b<=shadow (all taps in the same edge),
//     commit_done=1 for exactly that cycle, idx<=0, go IDLE.
//   Framing error: err<=1 (sticky), the offending word is discarded, idx<=0, go IDLE.
//     b is untouched.
//   clear: highest priority over all other inputs. Goes IDLE, idx<=0, err<=0, no commit.
//     A transfer in the same cycle is ignored, though wr_ready was high.
//   sample_strobe outside PEND: ignored.
//   Strobe in the same cycle that the last word is accepted: no commit.
//     Commit occurs on the next strobe after PEND is entered.
//   Latency: final word accepted at edge T -> b updates at first strobe edge >= T+1.
//     Minimum 1 cycle.
//   b changes only on a commit edge or on reset. Between commits b is stable regardless of
//     host activity.
//   No arithmetic: values are stored verbatim. Width of every shadow entry is N.
//   Back-to-back sets: IDLE accepts a new first word the cycle after commit_done.
//   busy = (state != IDLE). err does not block new loads.
// TESTING
//   1. Reset mid-LOAD (2 words in) -> b==0, busy=0, err=0 immediately. Next full set loads normally.
//   2. DELAYS=3, N=32: write 1,2,3,4 (last on 4), strobe 5 cycles later -> b==0x00000004_00000003_00000002_00000001
//      on strobe edge, commit_done single pulse, b unchanged before strobe.
//   3. Early last on word 2 -> err=1, b keeps prior value, next 4-word set commits correctly
//      with err still 1. clear -> err=0.
//   4. Missing last on word 4 -> err=1, no PEND. Strobes produce no commit_done.
//   5. Strobe in same cycle as final transfer -> no commit that cycle. Commit on next strobe.
//      clear asserted while in PEND -> IDLE, no commit on later strobes.
//   6. wr_valid toggled randomly with gaps -> only valid&ready words counted.
//      wr_ready=0 throughout PEND; held wr_valid in PEND is accepted as word 0 after commit.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the tapped-delay FIR: collects one full coefficient set into
// a shadow bank over a valid/ready stream and publishes it atomically on a sample boundary.
module fir_coeff_loader #(
    parameter int DELAYS = 3,
    parameter int N      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [N-1:0]            wr_data,
    input  logic                    wr_last,
    input  logic                    clear,
    input  logic                    sample_strobe,
    output logic [(DELAYS+1)*N-1:0] b,
    output logic                    busy,
    output logic                    commit_done,
    output logic                    err
);

    localparam int IDX_W = (DELAYS < 1) ? 1 : $clog2(DELAYS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DELAYS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                    state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [N-1:0]              shadow_r [0:DELAYS];
    logic [(DELAYS+1)*N-1:0]   b_r;
    logic                      wr_ready_r;
    logic                      busy_r;
    logic                      commit_done_r;
    logic                      err_r;
    logic                      xfer_s;

    // A word moves only when the host offers it and the registered ready is high.
    always_comb begin
        xfer_s = wr_valid & wr_ready_r;
    end

    // Loader FSM; wr_ready and busy are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= '0;
            b_r           <= '0;
            wr_ready_r    <= 1'b0;
            busy_r        <= 1'b0;
            commit_done_r <= 1'b0;
            err_r         <= 1'b0;
            for (int k = 0; k <= DELAYS; k++) begin
                shadow_r[k] <= '0;
            end
        end else begin
            commit_done_r <= 1'b0;
            if (clear) begin
                state_r    <= IDLE;
                idx_r      <= '0;
                err_r      <= 1'b0;
                wr_ready_r <= 1'b1;
                busy_r     <= 1'b0;
                for (int k = 0; k <= DELAYS; k++) begin
                    shadow_r[k] <= '0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        wr_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        if (xfer_s) begin
                            if (wr_last) begin
                                err_r <= 1'b1;
                                idx_r <= '0;
                            end else begin
                                shadow_r[0] <= wr_data;
                                idx_r       <= IDX_W'(1);
                                state_r     <= LOAD;
                                busy_r      <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (xfer_s) begin
                            if ((idx_r == LAST_IDX) && wr_last) begin
                                shadow_r[idx_r] <= wr_data;
                                state_r         <= PEND;
                                wr_ready_r      <= 1'b0;
                            end else if ((idx_r != LAST_IDX) && !wr_last) begin
                                shadow_r[idx_r] <= wr_data;
                                idx_r           <= idx_r + IDX_W'(1);
                            end else begin
                                // Framing error: drop the word, keep b, restart the set.
                                err_r      <= 1'b1;
                                idx_r      <= '0;
                                state_r    <= IDLE;
                                busy_r     <= 1'b0;
                                wr_ready_r <= 1'b1;
                            end
                        end
                    end
                    PEND: begin
                        if (sample_strobe) begin
                            for (int k = 0; k <= DELAYS; k++) begin
                                b_r[k*N +: N] <= shadow_r[k];
                            end
                            commit_done_r <= 1'b1;
                            idx_r         <= '0;
                            state_r       <= IDLE;
                            wr_ready_r    <= 1'b1;
                            busy_r        <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        idx_r      <= '0;
                        wr_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_ready    = wr_ready_r;
    assign b           = b_r;
    assign busy        = busy_r;
    assign commit_done = commit_done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader (DELAYS=3, N=32).
module tb_fir_coeff_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [31:0]  wr_data = 32'd0;
    logic         wr_last = 1'b0;
    logic         clear = 1'b0;
    logic         sample_strobe = 1'b0;
    logic [127:0] b;
    logic         busy;
    logic         commit_done;
    logic         err;

    int checks = 0;
    int errors = 0;

    fir_coeff_loader #(.DELAYS(3), .N(32)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last), .clear(clear),
        .sample_strobe(sample_strobe), .b(b), .busy(busy),
        .commit_done(commit_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic l);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = 32'hDEAD_BEEF;
    endtask

    task automatic strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (b !== 128'd0) begin errors++; $display("FAIL reset_b got %h exp 0", b); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wr_ready); end
        checks++; if ({busy, err, commit_done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, err, commit_done}); end
        tick(); tick();
        rst = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk got %b exp 0", wr_ready); end
        tick();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk got %b exp 1", wr_ready); end
    endtask

    task automatic test_reset_mid_load();
        put(32'd10, 1'b0);
        put(32'd20, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midload_busy got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({b, busy, err} !== {128'd0, 2'b00}) begin errors++; $display("FAIL midload_rst got b=%h busy=%b err=%b exp 0", b, busy, err); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_set();
        put(32'd1, 1'b0);
        put(32'd2, 1'b0);
        put(32'd3, 1'b0);
        put(32'd4, 1'b1);
        checks++; if ({busy, wr_ready} !== 2'b10) begin errors++; $display("FAIL pend_flags got %b exp 10", {busy, wr_ready}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({b, commit_done} !== {128'd0, 1'b0}) begin errors++; $display("FAIL pre_strobe got b=%h cd=%b exp 0", b, commit_done); end
        end
        strobe();
        checks++; if (b !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL commit_b got %h exp 4_3_2_1", b); end
        checks++; if ({commit_done, busy} !== 2'b10) begin errors++; $display("FAIL commit_flags got %b exp 10", {commit_done, busy}); end
        tick();
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL commit_pulse got %b exp 0", commit_done); end
    endtask

    task automatic test_early_last();
        put(32'd5, 1'b0);
        put(32'd6, 1'b1);
        checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL early_last got err/busy %b exp 10", {err, busy}); end
        checks++; if (b !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL early_last_b got %h exp 4_3_2_1", b); end
        put(32'd11, 1'b0); put(32'd12, 1'b0); put(32'd13, 1'b0); put(32'd14, 1'b1);
        strobe();
        checks++; if (b !== {32'd14, 32'd13, 32'd12, 32'd11}) begin errors++; $display("FAIL after_err_b got %h exp 14_13_12_11", b); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err got %b exp 0", err); end
    endtask

    task automatic test_missing_last();
        put(32'd21, 1'b0); put(32'd22, 1'b0); put(32'd23, 1'b0); put(32'd24, 1'b0);
        checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL missing_last got err/busy %b exp 10", {err, busy}); end
        for (int i = 0; i < 3; i++) begin
            strobe();
            checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL missing_last_cd got %b exp 0", commit_done); end
        end
        checks++; if (b !== {32'd14, 32'd13, 32'd12, 32'd11}) begin errors++; $display("FAIL missing_last_b got %h exp 14_13_12_11", b); end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_strobe_edge_and_clear();
        put(32'd31, 1'b0); put(32'd32, 1'b0); put(32'd33, 1'b0);
        sample_strobe = 1'b1;
        put(32'd34, 1'b1);
        sample_strobe = 1'b0;
        checks++; if ({commit_done, busy} !== 2'b01) begin errors++; $display("FAIL same_cycle_strobe got cd/busy %b exp 01", {commit_done, busy}); end
        strobe();
        checks++; if ({b, commit_done} !== {32'd34, 32'd33, 32'd32, 32'd31, 1'b1}) begin errors++; $display("FAIL next_strobe got b=%h cd=%b exp 34_33_32_31 1", b, commit_done); end
        put(32'd41, 1'b0); put(32'd42, 1'b0); put(32'd43, 1'b0); put(32'd44, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if ({busy, wr_ready} !== 2'b01) begin errors++; $display("FAIL clear_pend got busy/ready %b exp 01", {busy, wr_ready}); end
        strobe();
        checks++; if ({b, commit_done} !== {32'd34, 32'd33, 32'd32, 32'd31, 1'b0}) begin errors++; $display("FAIL clear_no_commit got b=%h cd=%b exp 34_33_32_31 0", b, commit_done); end
        clear = 1'b1;
        put(32'd99, 1'b0);
        clear = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_xfer got busy %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        int n = 0;
        logic acc;
        words[0] = 32'd51; words[1] = 32'd52; words[2] = 32'd53; words[3] = 32'd54;
        for (int c = 0; c < 200 && n < 4; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = wr_valid ? words[n] : 32'hBAD0_0000;
            wr_last  = wr_valid && (n == 3);
            acc = wr_valid & wr_ready;
            tick();
            if (acc) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL gap_words got %0d exp 4", n); end
        wr_valid = 1'b1; wr_data = 32'd61; wr_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({wr_ready, busy} !== 2'b01) begin errors++; $display("FAIL pend_ready got ready/busy %b exp 01", {wr_ready, busy}); end
        end
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        checks++; if ({b, commit_done} !== {32'd54, 32'd53, 32'd52, 32'd51, 1'b1}) begin errors++; $display("FAIL gap_commit got b=%h cd=%b exp 54_53_52_51 1", b, commit_done); end
        tick();
        wr_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_word0 got busy %b exp 1", busy); end
        put(32'd62, 1'b0); put(32'd63, 1'b0); put(32'd64, 1'b1);
        strobe();
        checks++; if (b !== {32'd64, 32'd63, 32'd62, 32'd61}) begin errors++; $display("FAIL b2b_b got %h exp 64_63_62_61", b); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_full_set();
        test_early_last();
        test_missing_last();
        test_strobe_edge_and_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
